// File: rtl/bus_dbg_pkg.sv
// rtl/bus_dbg_pkg.sv - command/response bytes and state encoding for the serial debug bus bridge
package bus_dbg_pkg;

  // Host command bytes
  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_P = 8'h50;

  // Single-byte responses
  localparam logic [7:0] RSP_K = 8'h4B;
  localparam logic [7:0] RSP_Q = 8'h3F;
  localparam logic [7:0] RSP_T = 8'h54;

  // Frame/bus state machine encoding
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ADDR = 3'd1;
  localparam logic [2:0] DATA = 3'd2;
  localparam logic [2:0] BUS  = 3'd3;
  localparam logic [2:0] RESP = 3'd4;

endpackage

// File: rtl/bus_dbg_bridge.sv
// rtl/bus_dbg_bridge.sv - byte-stream command frames to native valid/ready memory bus master
module bus_dbg_bridge
  import bus_dbg_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  logic [2:0]        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              is_wr_q, is_wr_d;
  logic              rsp_multi_q, rsp_multi_d;
  logic [7:0]        rsp_q, rsp_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic rx_fire;
  logic tx_fire;

  // rx_ready is held low while rst is asserted, even once the state has settled to IDLE
  assign rx_ready  = !rst && (state_q == IDLE || state_q == ADDR || state_q == DATA);
  assign rx_fire   = rx_valid && rx_ready;
  assign tx_valid  = (state_q == RESP);
  assign tx_fire   = tx_valid && tx_ready;
  // Read data leaves MSB first from the top of the shifting data register
  assign tx_data   = tx_valid ? (rsp_multi_q ? data_q[31:24] : rsp_q) : 8'h00;
  assign mem_valid = (state_q == BUS);
  assign mem_addr  = addr_q & 32'hFFFF_FFFC;
  assign mem_wdata = data_q;
  assign mem_wstrb = (mem_valid && is_wr_q) ? 4'hF : 4'h0;
  assign busy      = (state_q != IDLE);

  // Next-state: frame parsing, bus wait/timeout and response sequencing
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    is_wr_d     = is_wr_q;
    rsp_multi_d = rsp_multi_q;
    rsp_d       = rsp_q;
    wait_d      = wait_q;
    case (state_q)
      IDLE: begin
        if (rx_fire) begin
          cnt_d       = 2'd0;
          wait_d      = '0;
          rsp_multi_d = 1'b0;
          if (rx_data == CMD_W || rx_data == CMD_R) begin
            state_d = ADDR;
            is_wr_d = (rx_data == CMD_W);
          end else if (rx_data == CMD_P) begin
            state_d = RESP;
            rsp_d   = RSP_K;
          end else begin
            state_d = RESP;
            rsp_d   = RSP_Q;
          end
        end
      end
      ADDR: begin
        if (rx_fire) begin
          addr_d = {addr_q[23:0], rx_data};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = is_wr_q ? DATA : BUS;
          end
        end
      end
      DATA: begin
        if (rx_fire) begin
          data_d = {data_q[23:0], rx_data};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = BUS;
          end
        end
      end
      BUS: begin
        // Completion is checked before the timeout so a ready in the last cycle still wins
        if (mem_ready) begin
          state_d = RESP;
          cnt_d   = 2'd0;
          if (is_wr_q) begin
            rsp_d       = RSP_K;
            rsp_multi_d = 1'b0;
          end else begin
            data_d      = mem_rdata;
            rsp_multi_d = 1'b1;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d     = RESP;
          rsp_d       = RSP_T;
          rsp_multi_d = 1'b0;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      RESP: begin
        if (tx_fire) begin
          if (rsp_multi_q && cnt_q != 2'd3) begin
            data_d = {data_q[23:0], 8'h00};
            cnt_d  = cnt_q + 2'd1;
          end else begin
            state_d = IDLE;
            cnt_d   = 2'd0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      addr_q      <= 32'h0;
      data_q      <= 32'h0;
      is_wr_q     <= 1'b0;
      rsp_multi_q <= 1'b0;
      rsp_q       <= 8'h00;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      is_wr_q     <= is_wr_d;
      rsp_multi_q <= rsp_multi_d;
      rsp_q       <= rsp_d;
      wait_q      <= wait_d;
    end
  end

endmodule

// File: tb/tb_bus_dbg_bridge.sv
// tb/tb_bus_dbg_bridge.sv - randomized self-checking bench for bus_dbg_bridge
module tb_bus_dbg_bridge;

  localparam int TMO = 8;

  typedef logic [7:0] bq_t [$];

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        busy;

  always #5 clk = ~clk;

  bus_dbg_bridge #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit [31:0] dflt(input bit [31:0] a);
    return a ^ 32'h5A3C_96E1;
  endfunction

  // Bus slave state: responder memory, access capture
  bit [31:0]   smem [bit [31:0]];
  int          delay = 0;
  int          cyc = 0;
  int          acc_cnt = 0;
  int          last_len = 0;
  int          unstable = 0;
  bit          done_prev = 0;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_wstrb;

  // Reference model memory (what the host should read back)
  bit [31:0]   mmem [bit [31:0]];

  // TX sink state
  int          txmode = 0;
  logic [7:0]  txq [$];
  bit          held_prev = 0;
  logic [7:0]  held_data;
  int          rxv = 0;

  // Responder: ready after 'delay' wait cycles (-1 never), noise on mem_ready while idle
  always @(negedge clk) begin
    if (done_prev) check("done_latency", {mem_valid, tx_valid}, 2'b01);
    done_prev = 0;
    if (mem_valid) begin
      cyc++;
      if (cyc == 1) begin
        acc_cnt++;
        cap_addr = mem_addr; cap_wdata = mem_wdata; cap_wstrb = mem_wstrb;
      end else if (mem_addr !== cap_addr || mem_wdata !== cap_wdata || mem_wstrb !== cap_wstrb) begin
        unstable++;
      end
      if (delay >= 0 && cyc == delay + 1) begin
        mem_ready = 1'b1;
        done_prev = 1;
        if (mem_wstrb == 4'hF) smem[mem_addr] = mem_wdata;
        else mem_rdata = smem.exists(mem_addr) ? smem[mem_addr] : dflt(mem_addr);
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
      end
    end else begin
      if (cyc > 0) last_len = cyc;
      cyc = 0;
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
    end
  end

  // TX sink and rx_ready-while-busy monitor
  always @(negedge clk) begin
    case (txmode)
      0: tx_ready = 1'b1;
      1: tx_ready = ~tx_ready;
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
    if ((mem_valid || tx_valid) && rx_ready) rxv++;
    if (tx_valid && held_prev) check("tx_hold", tx_data, held_data);
    if (tx_valid && tx_ready) txq.push_back(tx_data);
    held_prev = tx_valid && !tx_ready && !rst;
    held_data = tx_data;
  end

  // Expected response and bus behaviour for one frame, from the frame rules alone
  function automatic void model(input logic [7:0] cmd, input bit [31:0] a, input bit [31:0] d,
                                input int dly, output bq_t exp, output int acc, output int len);
    bit ok;
    bit [31:0] wa;
    bit [31:0] v;
    ok  = (dly >= 0 && dly < TMO);
    wa  = {a[31:2], 2'b00};
    exp = {};
    acc = 0;
    len = 0;
    if (cmd == 8'h57 || cmd == 8'h52) begin
      acc = 1;
      len = ok ? dly + 1 : TMO;
      if (!ok) exp.push_back(8'h54);
      else if (cmd == 8'h57) begin
        mmem[wa] = d;
        exp.push_back(8'h4B);
      end else begin
        v = mmem.exists(wa) ? mmem[wa] : dflt(wa);
        exp = {v[31:24], v[23:16], v[15:8], v[7:0]};
      end
    end else if (cmd == 8'h50) begin
      exp.push_back(8'h4B);
    end else begin
      exp.push_back(8'h3F);
    end
  endfunction

  function automatic bq_t frame(input logic [7:0] cmd, input bit [31:0] a, input bit [31:0] d);
    bq_t f;
    f = {cmd};
    if (cmd == 8'h57 || cmd == 8'h52) f = {f, a[31:24], a[23:16], a[15:8], a[7:0]};
    if (cmd == 8'h57) f = {f, d[31:24], d[23:16], d[15:8], d[7:0]};
    return f;
  endfunction

  // Present a byte (rx_valid stays high); returns at the negedge after the transfer
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) check("rx_accept_wait", rx_ready, 1'b1);
    @(negedge clk);
  endtask

  task automatic wait_idle(input int want);
    int n;
    n = 0;
    while ((busy || txq.size() < want) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", busy, 1'b0);
    check("rx_ready_idle", rx_ready, 1'b1);
  endtask

  task automatic cmp_rsp(input bq_t exp);
    check("rsp_len", txq.size(), exp.size());
    for (int i = 0; i < exp.size() && i < txq.size(); i++) check("rsp_byte", txq[i], exp[i]);
  endtask

  task automatic xact(input logic [7:0] cmd, input bit [31:0] a, input bit [31:0] d,
                      input int dly, input int txm);
    bq_t exp;
    bq_t f;
    int  acc, len, acc0;
    delay  = dly;
    txmode = txm;
    model(cmd, a, d, dly, exp, acc, len);
    f    = frame(cmd, a, d);
    acc0 = acc_cnt;
    txq.delete();
    foreach (f[i]) send_byte(f[i]);
    if (acc == 1) check("issue_latency", mem_valid, 1'b1);
    rx_valid = 1'b0;
    wait_idle(exp.size());
    cmp_rsp(exp);
    check("access_count", acc_cnt - acc0, acc);
    if (acc == 1) begin
      check("mem_addr", cap_addr, {a[31:2], 2'b00});
      check("mem_wstrb", cap_wstrb, (cmd == 8'h57) ? 4'hF : 4'h0);
      if (cmd == 8'h57) check("mem_wdata", cap_wdata, d);
      check("valid_cycles", last_len, len);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bq_t e1, e2, f1, f2, both;
    int  acc, len;
    int  delays [7] = '{0, 1, 2, 5, 7, 8, -1};
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
    mem_ready = 1'b0; mem_rdata = 32'h0;

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_rx_ready", rx_ready, 1'b0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_mem_valid", mem_valid, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_wstrb", mem_wstrb, 4'h0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_rx_ready", rx_ready, 1'b1);

    // Directed write / read / toggling tx_ready
    xact(8'h57, 32'h1000_0100, 32'hDEAD_BEEF, 0, 0);
    smem[32'h4] = 32'h1234_5678;
    mmem[32'h4] = 32'h1234_5678;
    xact(8'h52, 32'h0000_0007, 32'h0, 3, 0);
    xact(8'h52, 32'h0000_0007, 32'h0, 3, 1);

    // Timeout boundaries
    xact(8'h52, 32'h0000_0040, 32'h0, -1, 0);
    xact(8'h57, 32'h0000_0044, 32'hCAFE_F00D, 7, 0);
    xact(8'h57, 32'h0000_0048, 32'h1111_2222, 8, 0);
    xact(8'h52, 32'h0000_0044, 32'h0, 7, 2);

    // Unknown and ping
    xact(8'h41, 32'h0, 32'h0, 0, 0);
    xact(8'h50, 32'h0, 32'h0, 0, 0);

    // Reset after three address bytes
    txq.delete();
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    rx_valid = 1'b0;
    check("midframe_busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_frame_mem_valid", mem_valid, 1'b0);
    check("rst_frame_tx_valid", tx_valid, 1'b0);
    check("rst_frame_mem_addr", mem_addr, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    xact(8'h50, 32'h0, 32'h0, 0, 0);

    // Reset during BUS
    delay = -1;
    txq.delete();
    f1 = frame(8'h52, 32'h0000_0080, 32'h0);
    foreach (f1[i]) send_byte(f1[i]);
    rx_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    check("bus_pending", mem_valid, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_bus_mem_valid", mem_valid, 1'b0);
    check("rst_bus_tx_valid", tx_valid, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_bus_no_rsp", txq.size(), 0);
    xact(8'h50, 32'h0, 32'h0, 0, 0);

    // Back-to-back reads with rx_valid held high
    delay = 2; txmode = 2;
    model(8'h52, 32'h1000_0100, 32'h0, 2, e1, acc, len);
    model(8'h52, 32'h0000_0004, 32'h0, 2, e2, acc, len);
    f1 = frame(8'h52, 32'h1000_0100, 32'h0);
    f2 = frame(8'h52, 32'h0000_0004, 32'h0);
    txq.delete();
    foreach (f1[i]) send_byte(f1[i]);
    foreach (f2[i]) send_byte(f2[i]);
    rx_valid = 1'b0;
    both = {e1, e2};
    wait_idle(both.size());
    cmp_rsp(both);

    // Randomized frames
    for (int it = 0; it < 30; it++) begin
      int r;
      logic [7:0] cmd;
      bit [31:0] a;
      r = $urandom_range(0, 9);
      if (r < 4) cmd = 8'h57;
      else if (r < 8) cmd = 8'h52;
      else if (r == 8) cmd = 8'h50;
      else begin
        cmd = 8'($urandom);
        while (cmd == 8'h57 || cmd == 8'h52 || cmd == 8'h50) cmd = 8'($urandom);
      end
      a = 32'h2000_0000 | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      xact(cmd, a, $urandom, delays[$urandom_range(0, 6)], $urandom_range(0, 2));
    end

    check("rx_ready_while_busy", rxv, 0);
    check("bus_signals_stable", unstable, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
